// File: rtl/avln_st_byte_ser.sv
// avln_st_byte_ser: Avalon-ST W-bit word to B-bit symbol serializer.
// Define AVLN_ST_BYTE_SER_PROTO_CHECK_EN to build sink packet-protocol checking on proto_err.
module avln_st_byte_ser #(
  parameter int B = 8,
  parameter int W = 32,
  localparam int BPW = W / B,
  localparam int EW = $clog2(BPW)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  in_data,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic [EW-1:0] in_empty,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [B-1:0]  out_data,
  output logic          out_sop,
  output logic          out_eop,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          proto_err
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [W-1:0] hw_q, hw_d;
  logic h_sop_q, h_sop_d, h_eop_q, h_eop_d;
  logic [EW-1:0] idx_q, idx_d, lim_q, lim_d;
  logic xfer, done, acc;
  // The held word shifts left per symbol, so the current symbol is always the top B bits
  assign out_valid = state_q == SHIFT;
  assign out_data  = hw_q[W-1 -: B];
  assign out_sop   = out_valid && h_sop_q && idx_q == '0;
  assign out_eop   = out_valid && h_eop_q && idx_q == lim_q;
  assign xfer      = out_valid && out_ready;
  assign done      = xfer && idx_q == lim_q;
  assign in_ready  = !reset && (state_q == IDLE || done);
  assign acc       = in_valid && in_ready;
  // BPW is a power of 2, so BPW-1-in_empty reduces to ~in_empty
  always_comb begin
    state_d = acc ? SHIFT : done ? IDLE : state_q;
    hw_d    = acc ? in_data : xfer ? hw_q << B : hw_q;
    h_sop_d = acc ? in_sop : h_sop_q;
    h_eop_d = acc ? in_eop : h_eop_q;
    idx_d   = acc ? '0 : (xfer && !done) ? idx_q + 1'b1 : idx_q;
    lim_d   = acc ? (in_eop ? ~in_empty : '1) : lim_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hw_q    <= '0;
      h_sop_q <= 1'b0;
      h_eop_q <= 1'b0;
      idx_q   <= '0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      hw_q    <= hw_d;
      h_sop_q <= h_sop_d;
      h_eop_q <= h_eop_d;
      idx_q   <= idx_d;
      lim_q   <= lim_d;
    end
  end
`ifdef AVLN_ST_BYTE_SER_PROTO_CHECK_EN
  logic in_pkt_q, in_pkt_d, err_q, err_d;
  // An sop+eop word opens and closes the packet in one accept
  always_comb begin
    in_pkt_d = acc ? !in_eop && (in_sop || in_pkt_q) : in_pkt_q;
    err_d    = acc && (in_sop == in_pkt_q || (in_empty != '0 && !in_eop));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      in_pkt_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      in_pkt_q <= in_pkt_d;
      err_q    <= err_d;
    end
  end
  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif
endmodule

// File: doc/avln_st_byte_ser.md
# avln_st_byte_ser

Avalon-ST width serializer: accepts packets on a W-bit `avln_st` sink (sop/eop/empty per `global_types`) and emits them as a B-bit symbol stream with sop/eop on the source side. It sits at the egress of the word-wide datapath, feeding byte-wide consumers such as UART/PHY adapters and byte-oriented checkers. It is the byte-side counterpart of the word-packing ingress. Sustained throughput is one symbol per cycle, with no bubble between consecutive words.

## Interface
- `B`, default 8: symbol width in bits (`global_types::B`).
- `W`, default 32: word width in bits (`global_types::W`); `BpW = W/B`, a power of 2 ≥ 2.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  W  word; first symbol in `[W-1 -: B]`.
- `in_sop`, `in_eop`  in  1 each  packet delimiters.
- `in_empty`  in  $clog2(BpW)  unused trailing symbols; honoured only with `in_eop`.
- `in_valid`  in  1 / `in_ready`  out  1  sink handshake.
- `out_data`  out  B  symbol.
- `out_sop`, `out_eop`  out  1 each  symbol delimiters.
- `out_valid`  out  1 / `out_ready`  in  1  source handshake.
- `proto_err`  out  1  one-cycle protocol-violation pulse (see Configuration).

## Operation
- Held-word register `hw`, flags `h_sop`/`h_eop`, symbol index `idx`, last index `lim`.
- States:
  - IDLE: nothing held.
  - SHIFT: word held; symbols are being emitted.
- Accept: a transfer occurs when `in_valid && in_ready`.
  - Load `hw`, `h_sop`, `h_eop`; set `idx=0`.
  - `lim = in_eop ? BpW-1-in_empty : BpW-1`.
  - Go to SHIFT.
- Output outputs are driven only from registered state.
  - `out_valid = (state==SHIFT)`.
  - `out_data = hw[W-1-B*idx -: B]`.
  - `out_sop = h_sop && idx==0`.
  - `out_eop = h_eop && idx==lim`.
- Emit: a symbol transfers when `out_valid && out_ready`.
  - If `idx<lim`, increment `idx`.
  - If `idx==lim`, the word is done.
- `in_ready = !reset && (state==IDLE || (out_valid && out_ready && idx==lim))`. This is combinational, so a new word loads in the same cycle the last symbol leaves (zero bubble).
- Word done with no new accept: return to IDLE.
- Word done with a simultaneous accept: stay in SHIFT with the new word loaded.
- `in_empty` with `in_eop=0` is ignored (treated as 0).
- `in_empty=BpW-1` with eop produces exactly one symbol, carrying `out_eop` (and `out_sop` if `in_sop`).
- `out_data` when `out_valid=0` is don't-care, but must not be X after reset (`hw` resets to 0).

## Timing
- Reset values: `out_valid=0`, `out_sop=0`, `out_eop=0`, `out_data=0`, `proto_err=0`, state IDLE, `idx=0`, `in_ready=0` while reset asserted.
- `in_ready=1` in the first cycle after reset deasserts.
- Latency: a word accepted in cycle N presents its first symbol in cycle N+1.
- A full word occupies BpW cycles under `out_ready=1`; the next word's first symbol follows with no gap.
- Backpressure: while `out_ready=0`, `out_*` hold stable and `in_ready=0` (when in SHIFT).
- Once `out_valid` rises, it never drops without a transfer.
- Reset mid-packet: the held word is discarded, nothing further is emitted, and there is no partial eop. The next packet on the source starts clean.

## Configuration
- Macro: `AVLN_ST_BYTE_SER_PROTO_CHECK_EN`.
- Defined: an `in_pkt` flag tracks sink packet state (set on accepted sop, cleared on accepted eop).
  - `proto_err` pulses one cycle after an accept carrying any of: sop while `in_pkt=1`; no sop while `in_pkt=0`; `in_empty!=0` without eop.
  - The word is still serialized unchanged; `in_pkt` updates normally, with sop forcing it to 1.
- Undefined: `proto_err` is tied 0, and no tracking logic is built. Datapath behaviour is identical.

## Test plan
- Single-word packet 0xA1B2C3D4, sop+eop, empty=0, `out_ready=1` -> symbols A1(sop), B2, C3, D4(eop) on 4 consecutive cycles starting 1 cycle after accept.
- 6-byte packet: 0x01020304 (sop), then 0x0506xxxx (eop, empty=2) -> 01(sop)…06(eop), 6 contiguous symbols, with no 3rd/4th symbol from word 2.
- Random `out_ready` (50%) over 100 packets of 1–64 bytes -> byte sequence and sop/eop match the scoreboard, and outputs are stable during stalls.
- Back-to-back words with `in_valid` held high -> `in_ready` pulses exactly on each last-symbol transfer and `out_valid` stays continuously 1.
- Reset asserted after 2nd symbol of a 4-symbol word -> `out_valid=0` next cycle, and the next packet's first symbol carries sop.
- With the macro: word without sop after idle -> `proto_err=1` for one cycle. Without the macro -> `proto_err` stays 0.
